// File: rtl/md_unit_pkg.sv
// Shared MIPS multiply/divide definitions: MDOp encodings, latency defaults, FSM states.
`ifndef MIPS_DEF
`define MIPS_DEF
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_launch(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage
`endif

// File: rtl/md_unit_calc.sv
// Combinational multiply/divide datapath working on the latched operands.
module md_calc
  import md_unit_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  md_op_e      op,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [31:0] sq_mag, sr_mag, uq, ur;
  logic [63:0] prod_s, prod_u;

  assign a_neg = a[31];
  assign b_neg = b[31];
  // Magnitude of 0x80000000 stays 0x80000000 as unsigned, which makes
  // 0x80000000 / -1 fall out as 0x80000000 with remainder 0.
  assign a_mag = a_neg ? (~a + 32'd1) : a;
  assign b_mag = b_neg ? (~b + 32'd1) : b;

  assign sq_mag = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
  assign sr_mag = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
  assign uq     = (b == 32'd0) ? 32'd0 : a / b;
  assign ur     = (b == 32'd0) ? 32'd0 : a % b;

  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  always_comb begin
    result      = 64'd0;
    div_by_zero = 1'b0;
    case (op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV: begin
        div_by_zero = (b == 32'd0);
        result[31:0]  = (a_neg ^ b_neg) ? (~sq_mag + 32'd1) : sq_mag;
        result[63:32] = a_neg ? (~sr_mag + 32'd1) : sr_mag;
      end
      MD_DIVU: begin
        div_by_zero = (b == 32'd0);
        result      = {ur, uq};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: launch FSM, latency counter and HI/LO registers.
//  state  | meaning
//  S_IDLE | accepts Start launches and MTHI/MTLO writes
//  S_RUN  | operation in flight, counter runs down, Busy high
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  md_state_e          state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        lat_a, lat_b, hi_q, lo_q;
  md_op_e             lat_op, op_in;
  logic               launch, finish, div_by_zero;
  logic [63:0]        result;

  assign op_in = md_op_e'(MDOp);

  md_calc u_calc (
    .a           (lat_a),
    .b           (lat_b),
    .op          (lat_op),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE: begin
        if (Start && is_launch(op_in)) begin
          launch    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt <= CNT_W'(1)) begin
          finish    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      lat_a  <= '0;
      lat_b  <= '0;
      lat_op <= MD_NONE;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        lat_a  <= A;
        lat_b  <= B;
        lat_op <= op_in;
        cnt    <= ((op_in == MD_DIV) || (op_in == MD_DIVU)) ? CNT_W'(DIV_CYCLES)
                                                            : CNT_W'(MULT_CYCLES);
      end else if (state == S_RUN) begin
        cnt <= cnt - CNT_W'(1);
      end
      // Divide by zero still burns the full latency but leaves HI/LO alone.
      if (finish && !div_by_zero) begin
        hi_q <= result[63:32];
        lo_q <= result[31:0];
      end else if (state == S_IDLE) begin
        if (op_in == MD_MTHI) hi_q <= A;
        if (op_in == MD_MTLO) lo_q <= A;
      end
    end
  end

  assign Busy = (state == S_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit with hand-computed HI/LO results.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [2:0]  MDOp;
  logic        Start;
  logic        Busy;
  logic [31:0] HI, LO;

  int checks   = 0;
  int failures = 0;
  logic [31:0] m_hi, m_lo;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .MDOp  (MDOp),
    .Start (Start),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Launch at the next edge, check Busy for n cycles with HI/LO held, then the result.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] ehi, input logic [31:0] elo);
    A = a; B = b; MDOp = op; Start = 1'b1;
    step();
    Start = 1'b0; MDOp = 3'd0; A = ~a; B = ~b;
    for (int k = 0; k < n; k++) begin
      chk({tag, "_busy"}, {31'd0, Busy}, 32'd1);
      if (k == n - 1) begin
        chk({tag, "_hi_held"}, HI, m_hi);
        chk({tag, "_lo_held"}, LO, m_lo);
      end
      step();
    end
    chk({tag, "_busy_done"}, {31'd0, Busy}, 32'd0);
    chk({tag, "_hi"}, HI, ehi);
    chk({tag, "_lo"}, LO, elo);
    m_hi = ehi;
    m_lo = elo;
  endtask

  initial begin
    reset = 1'b1; A = '0; B = '0; MDOp = 3'd0; Start = 1'b0;
    m_hi = '0; m_lo = '0;
    step(); step();
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    reset = 1'b0;

    run_op("mult",  3'd1, 32'hFFFF_FFFE, 32'd3,        5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div",   3'd3, 32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_pn", 3'd3, 32'd7, 32'hFFFF_FFFE,       10, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    run_op("divu",  3'd4, 32'hFFFF_FFFF, 32'h10,       10, 32'h0000_000F, 32'h0FFF_FFFF);
    run_op("divu0", 3'd4, 32'd1234, 32'd0,             10, 32'h0000_000F, 32'h0FFF_FFFF);
    run_op("div0",  3'd3, 32'hFFFF_FF00, 32'd0,        10, 32'h0000_000F, 32'h0FFF_FFFF);

    // MTHI / MTLO single-cycle writes
    MDOp = 3'd5; A = 32'h1234_5678;
    step();
    MDOp = 3'd0; A = 32'hAAAA_AAAA;
    chk("mthi_hi", HI, 32'h1234_5678);
    chk("mthi_lo", LO, 32'h0FFF_FFFF);
    chk("mthi_busy", {31'd0, Busy}, 32'd0);
    MDOp = 3'd6; A = 32'hCAFE_F00D;
    step();
    MDOp = 3'd0;
    chk("mtlo_lo", LO, 32'hCAFE_F00D);
    chk("mtlo_hi", HI, 32'h1234_5678);
    m_hi = 32'h1234_5678; m_lo = 32'hCAFE_F00D;

    // Start with non-launch ops
    MDOp = 3'd0; Start = 1'b1;
    step();
    Start = 1'b0;
    chk("start_none_busy", {31'd0, Busy}, 32'd0);
    MDOp = 3'd5; A = 32'h0000_0055; Start = 1'b1;
    step();
    Start = 1'b0; MDOp = 3'd0;
    chk("start_mthi_busy", {31'd0, Busy}, 32'd0);
    chk("start_mthi_hi", HI, 32'h0000_0055);
    m_hi = 32'h0000_0055;

    // MTLO and a second Start during RUN are ignored
    A = 32'd6; B = 32'd7; MDOp = 3'd1; Start = 1'b1;
    step();
    Start = 1'b0; MDOp = 3'd6; A = 32'hDEAD_BEEF;
    step();
    chk("run_mtlo_lo", LO, 32'hCAFE_F00D);
    MDOp = 3'd3; A = 32'd100; B = 32'd9; Start = 1'b1;
    step();
    Start = 1'b0; MDOp = 3'd0;
    step(); step();
    chk("run_busy4", {31'd0, Busy}, 32'd1);
    step();
    chk("run_busy_done", {31'd0, Busy}, 32'd0);
    chk("run_hi", HI, 32'd0);
    chk("run_lo", LO, 32'd42);
    m_hi = 32'd0; m_lo = 32'd42;

    // Reset four cycles into a DIV aborts it
    A = 32'd100; B = 32'd7; MDOp = 3'd3; Start = 1'b1;
    step();
    Start = 1'b0; MDOp = 3'd0;
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", {31'd0, Busy}, 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    for (int k = 0; k < 12; k++) step();
    chk("abort_late_busy", {31'd0, Busy}, 32'd0);
    chk("abort_late_hi", HI, 32'd0);
    chk("abort_late_lo", LO, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;

    // Back-to-back: second launch at the first idle cycle
    run_op("b2b_mult", 3'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 5, 32'd0, 32'd12);
    run_op("b2b_div",  3'd3, 32'd100, 32'd7,               10, 32'd2, 32'd14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit in the E stage of the pipelined MIPS core. It executes mult, multu, div, divu, mthi and mtlo with a fixed multi-cycle latency and holds the architectural HI/LO registers. It raises Busy so the hazard unit can stall dependent instructions. HI and LO feed the E-stage result select mux for mfhi/mflo.

## Interface
Parameters:
- MULT_CYCLES, 5, cycles Busy stays high for mult/multu
- DIV_CYCLES, 10, cycles Busy stays high for div/divu

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- A  input  32  rs operand (forwarded)
- B  input  32  rt operand (forwarded)
- MDOp  input  3  operation: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6
- Start  input  1  one-cycle pulse; launches MULT/MULTU/DIV/DIVU
- Busy  output  1  high while an operation is in flight
- HI  output  32  HI register
- LO  output  32  LO register

## Operation
- Reset: HI=0, LO=0, Busy=0, counter=0, latched operands=0. Reset mid-operation aborts it with no HI/LO write.
- State machine has two states, IDLE and RUN.
  - IDLE, Start=1, MDOp in {MULT, MULTU, DIV, DIVU}: latch A, B and MDOp; load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - RUN: decrement the counter each cycle. At the edge where counter reaches 0, write the result to HI/LO and go to IDLE.
- MULT: {HI,LO} = signed 64-bit A*B. MULTU: the unsigned product.
- DIV: LO = A/B, HI = A%B, signed. The quotient truncates toward zero; the remainder takes the sign of the dividend. 0x80000000 / -1 gives LO=0x80000000, HI=0. DIVU: the unsigned quotient and remainder.
- Divide by zero: Busy runs the full DIV_CYCLES, then HI/LO stay unchanged.
- MTHI/MTLO in IDLE: at the next edge, HI (or LO) takes A. No Busy and no Start needed.
- Start or MTHI/MTLO while in RUN: ignored. The hazard unit guarantees this case does not occur; the unit must still not corrupt state.
- Start with MDOp in {NONE, MTHI, MTLO}: no launch.
- Results are computed from the latched operands, so later changes on A/B during RUN have no effect.

## Timing
- Start is sampled at edge t. Busy is high after edge t and falls after edge t+N (N = MULT_CYCLES or DIV_CYCLES), so Busy is high for exactly N cycles.
- New HI/LO are visible after edge t+N, in the same cycle Busy falls.
- Busy is a registered output with no combinational path from Start. The hazard unit stalls md-class instructions in D on (Start | Busy).
- Back-to-back: a new Start is accepted in the first cycle Busy=0, i.e. edge t+N+1.
- MTHI/MTLO latency is 1 cycle. HI/LO are registered outputs.

## Structure
- Shared header with `ifndef guard (mips_def): MDOp encodings and MULT_CYCLES/DIV_CYCLES defaults.
- Combinational sub-module md_calc: takes the latched A, B and op and produces the 64-bit {hi,lo} result plus a div_by_zero flag. md_unit holds the FSM, counter and registers.

## Test plan
- Reset, then MULT A=0xFFFFFFFE(-2), B=3 -> Busy high for 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- DIV A=-7, B=2 -> Busy for 10 cycles; LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1). DIVU with B=0 -> Busy for 10 cycles, HI/LO unchanged.
- MTHI A=0x12345678 -> HI=0x12345678 after 1 edge, Busy stays 0. MTLO issued during RUN -> LO unchanged and the running op completes correctly.
- Start DIV, assert reset at cycle 4 -> next edge: Busy=0, HI=LO=0, and no later write occurs.
- MULT immediately followed by Start DIV at edge t+6 -> accepted; Busy is continuous across the boundary except for the one idle cycle; both results are correct in sequence.
